univ_shift_reg: RTL and testbench



---
 rtl/univ_shift_pkg.sv | 40 ++++
 rtl/univ_shift_reg_step.sv | 42 ++++
 rtl/univ_shift_reg.sv | 163 ++++++++++++++++
 tb/tb_univ_shift_reg.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_pkg.sv
// -----------------------------------------------------------------------------
// univ_shift_pkg
// Shared definitions for the universal shift register:
//   - op_e    : 3-bit operation codes (HOLD, LOAD, SHL, SHR, ROL, ROR, CLR, ASR)
//   - state_e : sequencer states (ST_IDLE, ST_RUN)
//   - is_shift: true for ops that move bits (SHL, SHR, ROL, ROR, ASR)
// -----------------------------------------------------------------------------
package univ_shift_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_CLR  = 3'b110,
        OP_ASR  = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Only bit-moving ops may be repeated by the multi-step sequencer;
    // HOLD/LOAD/CLR are idempotent and complete in a single edge.
    function automatic logic is_shift(input logic [OP_W-1:0] op);
        logic r_res;
        case (op)
            OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: r_res = 1'b1;
            OP_HOLD, OP_LOAD, OP_CLR:               r_res = 1'b0;
            default:                                r_res = 1'b0;
        endcase
        return r_res;
    endfunction

endpackage

// File: rtl/univ_shift_reg_step.sv
// -----------------------------------------------------------------------------
// univ_shift_reg_step
// Purely combinational single-step next-value unit. Given the current register
// value and an op code, produces the value after one application of the op.
// Ports:
//   i_q      [WIDTH-1:0] current register contents
//   i_op     [2:0]       operation code (op_e)
//   i_d      [WIDTH-1:0] parallel load data
//   i_sin_l              serial in at MSB (SHR)
//   i_sin_r              serial in at LSB (SHL)
//   o_q_next [WIDTH-1:0] value after one step
// -----------------------------------------------------------------------------
module univ_shift_reg_step
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [OP_W-1:0]  i_op,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sin_l,
    input  logic             i_sin_r,
    output logic [WIDTH-1:0] o_q_next
);

    // One-step datapath mux over all eight op codes
    always_comb begin
        o_q_next = i_q;
        case (i_op)
            OP_HOLD: o_q_next = i_q;
            OP_LOAD: o_q_next = i_d;
            OP_SHL:  o_q_next = {i_q[WIDTH-2:0], i_sin_r};
            OP_SHR:  o_q_next = {i_sin_l, i_q[WIDTH-1:1]};
            OP_ROL:  o_q_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
            OP_ROR:  o_q_next = {i_q[0], i_q[WIDTH-1:1]};
            OP_CLR:  o_q_next = {WIDTH{1'b0}};
            OP_ASR:  o_q_next = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
            default: o_q_next = i_q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
// Parametrised universal register: parallel load, clear, single-step
// shift/rotate, and a multi-step "shift by N" sequenced by a down counter and
// a two-state FSM with busy/done handshake.
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   en                    single-step enable (IDLE only)
//   start                 start multi-step op (IDLE only, wins over en)
//   op    [2:0]           operation code
//   amt   [AMT_W-1:0]     step count for start
//   d     [WIDTH-1:0]     parallel load data
//   sin_l, sin_r          serial inputs at MSB / LSB
//   q     [WIDTH-1:0]     register contents
//   sout_l, sout_r        q MSB / q LSB
//   busy                  multi-step in progress (registered)
//   done                  one-cycle completion pulse (registered)
// -----------------------------------------------------------------------------
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
    localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

    // Architectural state
    logic [WIDTH-1:0] r_q;
    logic [AMT_W-1:0] r_cnt;
    logic [OP_W-1:0]  r_op;
    state_e           r_state;
    logic             r_busy;
    logic             r_done;

    // Next-state values
    logic [WIDTH-1:0] w_q_nxt;
    logic [AMT_W-1:0] w_cnt_nxt;
    logic [OP_W-1:0]  w_op_nxt;
    state_e           w_state_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    // Shared step unit: the latched op drives it while running, the live op
    // input drives it in IDLE.
    logic [OP_W-1:0]  w_step_op;
    logic [WIDTH-1:0] w_step_q;

    // Select which op code feeds the shared step unit
    always_comb begin
        w_step_op = op;
        if (r_state == ST_RUN) begin
            w_step_op = r_op;
        end else begin
            w_step_op = op;
        end
    end

    univ_shift_reg_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_q      (r_q),
        .i_op     (w_step_op),
        .i_d      (d),
        .i_sin_l  (sin_l),
        .i_sin_r  (sin_r),
        .o_q_next (w_step_q)
    );

    // Sequencer next-state: decides register update, counter, FSM and handshake
    always_comb begin
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
                if (start) begin
                    if (amt == CNT_ZERO) begin
                        // Zero-length request completes immediately, q untouched
                        w_done_nxt = 1'b1;
                    end else if (is_shift(op)) begin
                        // Latch the op; q does not move on this edge
                        w_op_nxt    = op;
                        w_cnt_nxt   = amt;
                        w_state_nxt = ST_RUN;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        // HOLD/LOAD/CLR need only one application
                        w_q_nxt    = w_step_q;
                        w_done_nxt = 1'b1;
                    end
                end else if (en) begin
                    w_q_nxt = w_step_q;
                end else begin
                    w_q_nxt = r_q;
                end
            end
            ST_RUN: begin
                w_q_nxt   = w_step_q;
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_busy_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // State register bank with asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q     <= {WIDTH{1'b0}};
            r_cnt   <= CNT_ZERO;
            r_op    <= OP_HOLD;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign q      = r_q;
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
// Self-checking bench for univ_shift_reg (WIDTH=8, AMT_W=4). A behavioural
// model tracks the expected register value using integer arithmetic.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

    logic       clk;
    logic       reset;
    logic       en;
    logic       start;
    logic [2:0] op;
    logic [3:0] amt;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic       busy;
    logic       done;

    int n_checks;
    int n_fail;
    logic [7:0] m_q;

    univ_shift_reg #(.WIDTH(8), .AMT_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .start  (start),
        .op     (op),
        .amt    (amt),
        .d      (d),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: one op applied to an 8-bit value, computed arithmetically
    function automatic logic [7:0] ref_step(input logic [7:0] v, input logic [2:0] o,
                                            input logic [7:0] dv, input bit sl, input bit sr);
        int x;
        int r;
        x = int'(v);
        case (o)
            3'd0: r = x;
            3'd1: r = int'(dv);
            3'd2: r = (x * 2 + int'(sr)) % 256;
            3'd3: r = x / 2 + int'(sl) * 128;
            3'd4: r = (x * 2) % 256 + x / 128;
            3'd5: r = x / 2 + (x % 2) * 128;
            3'd6: r = 0;
            default: r = x / 2 + (x / 128) * 128;
        endcase
        return r[7:0];
    endfunction

    function automatic bit ref_is_shift(input logic [2:0] o);
        return (o == 3'd2) || (o == 3'd3) || (o == 3'd4) || (o == 3'd5) || (o == 3'd7);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; start = 1'b0; op = 3'd0; amt = 4'd0; d = 8'd0;
        sin_l = 1'b0; sin_r = 1'b0;
    endtask

    // One single-step op via en, checked against the model
    task automatic single(input logic [2:0] o, input logic [7:0] dv, input bit sl, input bit sr);
        en = 1'b1; start = 1'b0; op = o; d = dv; sin_l = sl; sin_r = sr;
        m_q = ref_step(m_q, o, dv, sl, sr);
        tick();
        en = 1'b0;
        n_checks++;
        if (q !== m_q || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL single op=%0d: q=%h busy=%b done=%b, expected q=%h busy=0 done=0",
                     o, q, busy, done, m_q);
        end
        n_checks++;
        if (sout_l !== m_q[7] || sout_r !== m_q[0]) begin
            n_fail++;
            $display("FAIL sout: sout_l=%b sout_r=%b, expected %b %b", sout_l, sout_r, m_q[7], m_q[0]);
        end
    endtask

    // Full start transaction, cycle-checked; junk=1 scrambles inputs during RUN
    task automatic run_start(input logic [2:0] o, input int n, input logic [7:0] dv, input bit junk);
        bit sl;
        bit sr;
        start = 1'b1; op = o; amt = n[3:0]; d = dv; en = 1'($urandom_range(0, 1));
        sl = 1'($urandom_range(0, 1)); sr = 1'($urandom_range(0, 1));
        sin_l = sl; sin_r = sr;
        if (n != 0 && !ref_is_shift(o)) m_q = ref_step(m_q, o, dv, sl, sr);
        tick();
        start = 1'b0; en = 1'b0;
        if (n == 0 || !ref_is_shift(o)) begin
            n_checks++;
            if (q !== m_q || busy !== 1'b0 || done !== 1'b1) begin
                n_fail++;
                $display("FAIL start_immediate op=%0d amt=%0d: q=%h busy=%b done=%b, expected q=%h busy=0 done=1",
                         o, n, q, busy, done, m_q);
            end
        end else begin
            n_checks++;
            if (q !== m_q || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL start_e0 op=%0d amt=%0d: q=%h busy=%b done=%b, expected q=%h busy=1 done=0",
                         o, n, q, busy, done, m_q);
            end
            for (int k = 1; k <= n; k++) begin
                sl = 1'($urandom_range(0, 1)); sr = 1'($urandom_range(0, 1));
                sin_l = sl; sin_r = sr;
                if (junk) begin
                    start = 1'($urandom_range(0, 1)); en = 1'($urandom_range(0, 1));
                    op = 3'($urandom_range(0, 7)); amt = 4'($urandom_range(0, 15));
                    d = 8'($urandom_range(0, 255));
                end
                m_q = ref_step(m_q, o, dv, sl, sr);
                tick();
                n_checks++;
                if (q !== m_q || busy !== (k < n) || done !== (k == n)) begin
                    n_fail++;
                    $display("FAIL run_step op=%0d k=%0d/%0d: q=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
                             o, k, n, q, busy, done, m_q, (k < n), (k == n));
                end
            end
        end
        idle_inputs();
        tick();
        n_checks++;
        if (q !== m_q || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done op=%0d: q=%h busy=%b done=%b, expected q=%h busy=0 done=0",
                     o, q, busy, done, m_q);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_q = 8'h00;
        n_checks++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || sout_l !== 1'b0 || sout_r !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: q=%h busy=%b done=%b, expected q=00 busy=0 done=0", q, busy, done);
        end
    endtask

    task automatic test_single_step();
        single(3'd1, 8'hA5, 1'b0, 1'b0);
        n_checks++;
        if (q !== 8'hA5) begin
            n_fail++;
            $display("FAIL load_a5: q=%h, expected a5", q);
        end
        single(3'd4, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (q !== 8'h4B) begin
            n_fail++;
            $display("FAIL rol_4b: q=%h, expected 4b", q);
        end
        // en=0 must hold
        d = 8'hFF; op = 3'd1;
        tick();
        n_checks++;
        if (q !== 8'h4B) begin
            n_fail++;
            $display("FAIL hold_en0: q=%h, expected 4b", q);
        end
        for (int i = 0; i < 40; i++) begin
            single(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_multi_ror();
        single(3'd1, 8'hA5, 1'b0, 1'b0);
        run_start(3'd5, 3, 8'h00, 1'b0);
        n_checks++;
        if (q !== 8'hB4) begin
            n_fail++;
            $display("FAIL ror3: q=%h, expected b4", q);
        end
    endtask

    task automatic test_asr_shl();
        single(3'd1, 8'h80, 1'b0, 1'b0);
        run_start(3'd7, 2, 8'h00, 1'b0);
        n_checks++;
        if (q !== 8'hE0) begin
            n_fail++;
            $display("FAIL asr2: q=%h, expected e0", q);
        end
        single(3'd2, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (q !== 8'hC1 || sout_l !== 1'b1 || sout_r !== 1'b1) begin
            n_fail++;
            $display("FAIL shl_c1: q=%h sout_l=%b sout_r=%b, expected c1 1 1", q, sout_l, sout_r);
        end
    endtask

    task automatic test_rol_wrap();
        single(3'd1, 8'h01, 1'b0, 1'b0);
        run_start(3'd4, 9, 8'h00, 1'b1);
        n_checks++;
        if (q !== 8'h02) begin
            n_fail++;
            $display("FAIL rol9: q=%h, expected 02", q);
        end
    endtask

    task automatic test_immediate();
        run_start(3'd2, 0, 8'h00, 1'b0);
        run_start(3'd1, 5, 8'h3C, 1'b0);
        n_checks++;
        if (q !== 8'h3C) begin
            n_fail++;
            $display("FAIL load_start: q=%h, expected 3c", q);
        end
    endtask

    task automatic test_back_to_back();
        // Start accepted in the same cycle done is high
        single(3'd1, 8'h96, 1'b0, 1'b0);
        start = 1'b1; op = 3'd4; amt = 4'd1;
        tick();
        m_q = ref_step(m_q, 3'd4, 8'h00, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (done !== 1'b1 || q !== m_q) begin
            n_fail++;
            $display("FAIL b2b_first: q=%h done=%b, expected q=%h done=1", q, done, m_q);
        end
        start = 1'b1; op = 3'd5; amt = 4'd2;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b, expected busy=1 done=0", busy, done);
        end
        m_q = ref_step(ref_step(m_q, 3'd5, 8'h00, 1'b0, 1'b0), 3'd5, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        n_checks++;
        if (q !== m_q || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: q=%h busy=%b done=%b, expected q=%h busy=0 done=1", q, busy, done, m_q);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random_multi();
        for (int i = 0; i < 12; i++) begin
            run_start(3'($urandom_range(0, 7)), $urandom_range(0, 15), 8'($urandom_range(0, 255)), 1'b1);
        end
    endtask

    task automatic test_async_reset_midrun();
        single(3'd1, 8'hFF, 1'b0, 1'b0);
        start = 1'b1; op = 3'd3; amt = 4'd6; sin_l = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: q=%h busy=%b done=%b, expected q=00 busy=0 done=0", q, busy, done);
        end
        #2;
        reset = 1'b0;
        m_q = 8'h00;
        idle_inputs();
        single(3'd1, 8'h11, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (q !== 8'h11 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: q=%h busy=%b done=%b, expected q=11 busy=0 done=0", q, busy, done);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_q      = 8'h00;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_single_step();
        test_multi_ror();
        test_asr_shl();
        test_rol_wrap();
        test_immediate();
        test_back_to_back();
        test_random_multi();
        test_async_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
